// File: rtl/id_fetch_queue.sv
// IF->ID decoupling queue: DEPTH-entry first-word-fall-through FIFO carrying
// {inst, pc} plus a merged exception code and ECALL/MRET pre-decode bits.
// A flush (branch/jump redirect) or reset discards every queued entry.
module id_fetch_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int EXC_W = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    fs_to_ds_valid,
  input  logic [2*XLEN-1:0]       if_id_bus_in,
  input  logic [EXC_W-1:0]        exception_code_fd,
  output logic                    ds_allowin,
  output logic                    q_to_ds_valid,
  input  logic                    ds_ready,
  output logic [2*XLEN-1:0]       if_id_bus_out,
  output logic [EXC_W-1:0]        exception_code_de,
  output logic                    ecall_flag,
  output logic                    mret_flag,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = 2*XLEN + EXC_W + 2;

  localparam logic [XLEN-1:0]  INST_ECALL  = XLEN'(32'h0000_0073);
  localparam logic [XLEN-1:0]  INST_EBREAK = XLEN'(32'h0010_0073);
  localparam logic [XLEN-1:0]  INST_MRET   = XLEN'(32'h3020_0073);
  localparam logic [EXC_W-1:0] EXC_EBREAK  = EXC_W'(6'b100011);
  localparam logic [EXC_W-1:0] EXC_ECALL   = EXC_W'(6'b101011);
  localparam logic [EXC_W-1:0] EXC_MRET    = EXC_W'(6'b011111);

  // A valid fetch-side exception always wins over the decoded system instruction.
  function automatic logic [EXC_W-1:0] merge_exc(
    input logic [EXC_W-1:0] fd,
    input logic             is_ecall,
    input logic             is_ebreak,
    input logic             is_mret
  );
    if (fd[EXC_W-1])   return fd;
    else if (is_ebreak) return EXC_EBREAK;
    else if (is_ecall)  return EXC_ECALL;
    else if (is_mret)   return EXC_MRET;
    else                return '0;
  endfunction

  logic [EW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            empty, full, push, pop;

  logic [XLEN-1:0] inst_p0;
  logic            is_ecall_p0, is_ebreak_p0, is_mret_p0;
  logic [EW-1:0]   wr_entry_p0;

  logic [EW-1:0]   head_p1;
  logic [XLEN-1:0] head_inst_p1, head_pc_p1;
  logic [EXC_W-1:0] head_exc_p1;
  logic            head_ecall_p1, head_mret_p1;

  // Pointer bookkeeping: the extra MSB separates full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count = wr_ptr - rd_ptr;

  // Acceptance depends on occupancy only, never on ds_ready.
  assign ds_allowin    = !full;
  assign q_to_ds_valid = !empty && !flush;
  assign push          = fs_to_ds_valid && ds_allowin && !flush;
  assign pop           = q_to_ds_valid && ds_ready;

  // ---- p0: pre-decode the incoming entry at write time ----
  assign inst_p0      = if_id_bus_in[2*XLEN-1:XLEN];
  assign is_ecall_p0  = (inst_p0 == INST_ECALL);
  assign is_ebreak_p0 = (inst_p0 == INST_EBREAK);
  assign is_mret_p0   = (inst_p0 == INST_MRET);
  assign wr_entry_p0  = {if_id_bus_in,
                         merge_exc(exception_code_fd, is_ecall_p0, is_ebreak_p0, is_mret_p0),
                         is_ecall_p0, is_mret_p0};

  // Pointer update: reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage write; contents are not cleared, the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_entry_p0;
  end

  // ---- p1: fall-through head read, zero-muxed while invalid ----
  assign head_p1 = mem[rd_ptr[AW-1:0]];
  assign {head_inst_p1, head_pc_p1, head_exc_p1, head_ecall_p1, head_mret_p1} = head_p1;

  assign if_id_bus_out     = q_to_ds_valid ? {head_inst_p1, head_pc_p1} : '0;
  assign exception_code_de = q_to_ds_valid ? head_exc_p1 : '0;
  assign ecall_flag        = q_to_ds_valid && head_ecall_p1;
  assign mret_flag         = q_to_ds_valid && head_mret_p1;

endmodule
